// File: rtl/io_input_capture.sv
// io_input_capture: synchronized, debounced pushbutton and slide-switch capture behind a CPU read port.
// Optional feature: define IO_INPUT_IRQ_EN to add a registered irq output that follows "any key pressed".
module io_input_capture #(
    parameter int DATA_BIT_WIDTH  = 32,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                keys,
    input  logic [9:0]                switches,
    input  logic                      isKeyRead,
    input  logic                      isSwitchRead,
    output logic [DATA_BIT_WIDTH-1:0] ioOut
`ifdef IO_INPUT_IRQ_EN
    ,
    output logic                      irq
`endif
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [3:0] keySync1, keySync2, keyNow;
    logic [9:0] switchSync1, switchSync2;
    logic [1:0] syncValid;
    logic [3:0] keyStable, keyPressed, keyOverflow, keyBlocked, keyDone, keyRise;
    logic       keyClear;

    assign keyNow   = ~keySync2;
    assign keyRise  = keyDone & ~keyBlocked & ~keyStable;
    assign keyClear = isKeyRead & ~isSwitchRead;

    // two-flop synchronizers; syncValid marks when the second stage holds real input samples after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            keySync1    <= 4'hF;
            keySync2    <= 4'hF;
            switchSync1 <= '0;
            switchSync2 <= '0;
            syncValid   <= '0;
        end else begin
            keySync1    <= keys;
            keySync2    <= keySync1;
            switchSync1 <= switches;
            switchSync2 <= switchSync1;
            syncValid   <= {syncValid[0], 1'b1};
        end
    end

    for (genvar i = 0; i < 4; i++) begin : keyDebounce
        logic [CNT_W-1:0] count;
        logic             differ;
        // a blocked key is treated as already pressed, so it must first be seen released for a full debounce
        assign differ     = keyNow[i] != (keyBlocked[i] | keyStable[i]);
        assign keyDone[i] = syncValid[1] & differ & (count == CNT_W'(DEBOUNCE_CYCLES - 1));
        // count consecutive samples that disagree with the debounced level
        always_ff @(posedge clk) begin
            if (reset)
                count <= '0;
            else
                count <= (syncValid[1] & differ & ~keyDone[i]) ? count + 1'b1 : '0;
        end
    end

    // debounced level; after reset every key stays blocked until a debounced release is seen
    always_ff @(posedge clk) begin
        if (reset) begin
            keyStable  <= '0;
            keyBlocked <= 4'hF;
        end else begin
            keyStable  <= keyStable ^ (keyDone & ~keyBlocked);
            keyBlocked <= keyBlocked & ~keyDone;
        end
    end

    // sticky press/overflow flags; a new press wins over a same-cycle clearing read
    always_ff @(posedge clk) begin
        if (reset) begin
            keyPressed  <= '0;
            keyOverflow <= '0;
        end else begin
            keyPressed  <= (keyPressed & {4{~keyClear}}) | keyRise;
            keyOverflow <= keyClear ? '0 : keyOverflow | (keyRise & keyPressed);
        end
    end

    // read mux: switch read has priority over key read
    always_comb begin
        ioOut = isSwitchRead ? {{(DATA_BIT_WIDTH - 10){1'b0}}, switchSync2}
              : isKeyRead    ? {{(DATA_BIT_WIDTH - 12){1'b0}}, keyOverflow, keyPressed, keyStable}
              : '0;
    end

`ifdef IO_INPUT_IRQ_EN
    // interrupt follows "any key pressed" one cycle later
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= |keyPressed;
    end
`endif
endmodule

// File: doc/io_input_capture.md
IO_INPUT_CAPTURE -- requirements
Module: io_input_capture

Interface
REQ-001 Parameter DATA_BIT_WIDTH, default 32, width of the CPU read bus; SHALL be at least 16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable synchronized samples needed to accept a key change; SHALL be at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 keys  input  4  raw pushbuttons, asynchronous, active-low (0 = pressed).
REQ-006 switches  input  10  raw slide switches, asynchronous.
REQ-007 isKeyRead  input  1  CPU read strobe for the key status word.
REQ-008 isSwitchRead  input  1  CPU read strobe for the switch word.
REQ-009 ioOut  output  DATA_BIT_WIDTH  combinational read data.

Function
REQ-010 keys and switches SHALL each pass through a two-flop synchronizer before any other use.
REQ-011 The block SHALL invert the synchronized keys to active-high and keep a debounced level keyStable[3:0] (1 = pressed).
REQ-012 Each key SHALL have its own counter: reset to 0 while the synchronized value equals keyStable[i]; otherwise increment.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, keyStable[i] SHALL take the new value and the counter SHALL return to 0.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change keyStable.
REQ-015 A keyStable[i] 0->1 transition SHALL set sticky keyPressed[i]; a 1->0 transition SHALL NOT set any flag.
REQ-016 A 0->1 transition while keyPressed[i] is already 1 SHALL set sticky keyOverflow[i].
REQ-017 Key status word: bits[3:0]=keyStable, bits[7:4]=keyPressed, bits[11:8]=keyOverflow, all higher bits 0.
REQ-018 isKeyRead=1, isSwitchRead=0: ioOut SHALL present the key status word in the same cycle; keyPressed and keyOverflow SHALL clear at the end of that cycle (clear-on-read).
REQ-019 A new press in the same cycle as a clearing read: keyPressed[i] SHALL be 1 afterwards and keyOverflow[i] SHALL be 0 (set beats clear, overflow not raised).
REQ-020 isSwitchRead=1: ioOut SHALL be {zeros, synchronized switches[9:0]}, with no key clear, regardless of isKeyRead.
REQ-021 Both strobes 0: ioOut SHALL be 0 and no sticky bit SHALL clear.
REQ-022 Read latency from raw switch change to ioOut SHALL be exactly 2 cycles; from raw key change to keyStable, 2+DEBOUNCE_CYCLES cycles.

Reset
REQ-023 reset=1 at a clock edge SHALL clear synchronizers to the released/0 value, keyStable, keyPressed, keyOverflow and all counters to 0; irq (if present) SHALL be 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no press SHALL be reported for a key held through reset until its release and re-press have each been debounced.

Configuration
REQ-025 Macro IO_INPUT_IRQ_EN defined: output port irq (1 bit) SHALL exist, registered, high the cycle after any keyPressed bit is 1 and low the cycle after all are 0.
REQ-026 IO_INPUT_IRQ_EN undefined: no irq port and no related logic; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 keys[0] driven 0 and held -> keyStable[0]=1 after 6 cycles; key read returns 0x011, next key read returns 0x001.
REQ-028 keys[1] pulsed low for 3 cycles -> key read returns 0x000 throughout.
REQ-029 key 2 pressed, released, pressed, each held 10 cycles, no read -> key read returns 0x444 (while held), next read 0x004.
REQ-030 switches=0x2A5 at cycle t, isSwitchRead=1 -> ioOut=0x2A5 from cycle t+2; keyPressed unchanged with isKeyRead also high.
REQ-031 Press on key 3 debounced in the same cycle as isKeyRead -> following read returns 0x088 (level and flag) with bit 11 = 0.
REQ-032 reset pulsed while key 0 is held and counter is at 2 -> all reads return 0x000 until release and re-press; with IO_INPUT_IRQ_EN, irq stays 0 until that re-press is debounced.
